// File: rtl/io_out_fifo_pkg.sv
// Shared width helpers and default parameters for the processor output FIFO.
// Every file of the block derives its widths from these functions.
package io_out_fifo_pkg;

    localparam int DEF_NUBITS = 16;
    localparam int DEF_NUIOOU = 2;
    localparam int DEF_FDEPTH = 8;
    localparam int DEF_AFULL  = 6;

    // A single output address still needs a one-bit field to stay legal
    function automatic int addr_width(input int nuioou);
        return (nuioou > 1) ? $clog2(nuioou) : 1;
    endfunction

    function automatic int entry_width(input int nubits, input int nuioou);
        return nubits + addr_width(nuioou);
    endfunction

    function automatic int ptr_width(input int fdepth);
        return $clog2(fdepth);
    endfunction

endpackage

// File: rtl/io_out_fifo_if.sv
// Valid/ready stream carrying buffered output writes (data plus port address).
// The FIFO drives the master side; the downstream consumer uses the slave side.
interface io_out_fifo_if
    import io_out_fifo_pkg::*;
#(
    parameter int NUBITS = DEF_NUBITS,
    parameter int AW     = addr_width(DEF_NUIOOU)
);
    logic [NUBITS-1:0] m_data;
    logic [AW-1:0]     m_addr;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_addr, output m_valid, input m_ready);
    modport slave  (input m_data, input m_addr, input m_valid, output m_ready);
endinterface

// File: rtl/io_out_fifo_mem.sv
// Register array with one synchronous write port and one asynchronous read port,
// so the entry at the read pointer is visible in the same cycle (fall-through head).
module io_out_fifo_mem
    import io_out_fifo_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];
endmodule

// File: rtl/io_out_fifo.sv
// Captures processor output writes into a first-word-fall-through FIFO and
// presents them on a valid/ready stream with full, almost-full and overflow status.
module io_out_fifo
    import io_out_fifo_pkg::*;
#(
    parameter int                NUBITS = DEF_NUBITS,
    parameter int                NUIOOU = DEF_NUIOOU,
    parameter int                FDEPTH = DEF_FDEPTH,
    parameter int                AFULL  = DEF_AFULL,
    parameter logic [NUIOOU-1:0] PSEL   = '1,
    localparam int               AW     = addr_width(NUIOOU),
    localparam int               EW     = entry_width(NUBITS, NUIOOU),
    localparam int               PW     = ptr_width(FDEPTH),
    localparam int               CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_en,
    input  logic [AW-1:0]     addr_out,
    input  logic [NUBITS-1:0] io_out,
    io_out_fifo_if.master     m_if,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              afull,
    output logic              ovf,
    input  logic              clr_ovf
);
    logic [PW-1:0]     wptr_reg, wptr_next, rptr_reg, rptr_next;
    logic [CW-1:0]     count_reg, count_next;
    logic              full_reg, full_next, afull_reg, afull_next;
    logic              valid_reg, valid_next, ovf_reg, ovf_next;
    logic [2**AW-1:0]  psel_ext;
    logic              push_req, pop, accept, overflow;
    logic [EW-1:0]     head;

    // Addresses beyond NUIOOU (non power-of-two port counts) are never captured
    for (genvar gi = 0; gi < 2**AW; gi++) begin : g_psel
        if (gi < NUIOOU) begin : g_sel
            assign psel_ext[gi] = PSEL[gi];
        end else begin : g_unsel
            assign psel_ext[gi] = 1'b0;
        end
    end

    assign push_req = out_en && psel_ext[addr_out];
    assign pop      = valid_reg && m_if.m_ready;
    // A pop in the same cycle frees the slot, so a push while full is still taken
    assign accept   = push_req && (!full_reg || pop);
    assign overflow = push_req && full_reg && !pop;

    always_comb begin
        wptr_next  = wptr_reg + PW'(accept);
        rptr_next  = rptr_reg + PW'(pop);
        count_next = count_reg + CW'(accept) - CW'(pop);
        full_next  = (count_next == CW'(FDEPTH));
        afull_next = (count_next >= CW'(AFULL));
        valid_next = (count_next != '0);
        ovf_next   = overflow || (ovf_reg && !clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            afull_reg <= 1'b0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wptr_reg  <= wptr_next;
            rptr_reg  <= rptr_next;
            count_reg <= count_next;
            full_reg  <= full_next;
            afull_reg <= afull_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
        end
    end

    io_out_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (FDEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (accept && !rst),
        .waddr (wptr_reg),
        .wdata ({addr_out, io_out}),
        .raddr (rptr_reg),
        .rdata (head)
    );

    // Stale array contents are masked so the stream reads zero while idle
    assign m_if.m_valid = valid_reg;
    assign m_if.m_data  = valid_reg ? head[NUBITS-1:0] : '0;
    assign m_if.m_addr  = valid_reg ? head[EW-1:NUBITS] : '0;

    assign count = count_reg;
    assign full  = full_reg;
    assign afull = afull_reg;
    assign ovf   = ovf_reg;
endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: queue-based reference model feeding a
// scoreboard, directed scenarios followed by randomized traffic.
module tb_io_out_fifo;
    import io_out_fifo_pkg::*;

    localparam int         NUBITS = 16;
    localparam int         NUIOOU = 2;
    localparam int         FDEPTH = 8;
    localparam int         AFULL  = 6;
    localparam int         AW     = 1;
    localparam int         CW     = 4;
    localparam logic [1:0] PSEL   = 2'b10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              out_en = 1'b0;
    logic [AW-1:0]     addr_out = '0;
    logic [NUBITS-1:0] io_out = '0;
    logic              m_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic [CW-1:0]     count;
    logic              full, afull, ovf;

    io_out_fifo_if #(.NUBITS(NUBITS), .AW(AW)) m_if ();
    assign m_if.m_ready = m_ready;

    io_out_fifo #(
        .NUBITS (NUBITS),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH),
        .AFULL  (AFULL),
        .PSEL   (PSEL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en),
        .addr_out (addr_out),
        .io_out   (io_out),
        .m_if     (m_if),
        .count    (count),
        .full     (full),
        .afull    (afull),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]     a;
        logic [NUBITS-1:0] d;
    } entry_t;

    entry_t exp_q[$];
    int     mod_count = 0;
    bit     mod_ovf   = 1'b0;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compares current state, then applies the upcoming edge
    always @(negedge clk) begin
        bit push, pop, lost;
        entry_t e;
        check("m_valid", m_if.m_valid, mod_count > 0);
        check("count", count, mod_count);
        check("full", full, mod_count == FDEPTH);
        check("afull", afull, mod_count >= AFULL);
        check("ovf", ovf, mod_ovf);
        if (!m_if.m_valid) check("idle_zero", {m_if.m_addr, m_if.m_data}, 0);
        if (rst) begin
            mod_count = 0;
            mod_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            push = out_en && PSEL[addr_out];
            pop  = (mod_count > 0) && m_ready;
            lost = 1'b0;
            if (push && (mod_count < FDEPTH || pop)) begin
                e.a = addr_out;
                e.d = io_out;
                exp_q.push_back(e);
                mod_count++;
            end else if (push) begin
                lost = 1'b1;
            end
            if (pop) mod_count--;
            if (lost) mod_ovf = 1'b1;
            else if (clr_ovf) mod_ovf = 1'b0;
        end
    end

    // Scoreboard monitor: every accepted output must match the oldest expected entry
    always @(negedge clk) begin
        entry_t h;
        if (!rst && m_if.m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop_empty: got data %0h, expected no entry", m_if.m_data);
            end else begin
                h = exp_q.pop_front();
                check("m_data", m_if.m_data, h.d);
                check("m_addr", m_if.m_addr, h.a);
            end
        end
    end

    task automatic cyc(input bit en, input logic [AW-1:0] a, input logic [NUBITS-1:0] d,
                       input bit rdy, input bit clr = 1'b0, input bit r = 1'b0);
        out_en   = en;
        addr_out = a;
        io_out   = d;
        m_ready  = rdy;
        clr_ovf  = clr;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (FDEPTH + 2) cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_count", count, 0);
        check("rst_valid", m_if.m_valid, 0);

        // Basic capture and fall-through
        cyc(1'b1, 1'b1, 16'h1234, 1'b0);
        check("basic_valid", m_if.m_valid, 1);
        check("basic_data", m_if.m_data, 16'h1234);
        check("basic_addr", m_if.m_addr, 1);
        check("basic_count", count, 1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        check("basic_pop_valid", m_if.m_valid, 0);
        check("basic_pop_count", count, 0);

        // Address filter: address 0 is not selected
        cyc(1'b1, 1'b0, 16'hAAAA, 1'b0);
        check("filter_count0", count, 0);
        check("filter_ovf", ovf, 0);
        cyc(1'b1, 1'b1, 16'h5555, 1'b0);
        check("filter_count1", count, 1);
        check("filter_data", m_if.m_data, 16'h5555);
        drain();

        // Fill, flags, overflow, clear
        for (int i = 0; i < FDEPTH; i++) begin
            cyc(1'b1, 1'b1, 16'(i), 1'b0);
            if (i == AFULL - 2) check("afull_below", afull, 0);
            if (i == AFULL - 1) check("afull_at", afull, 1);
            if (i == FDEPTH - 2) check("full_below", full, 0);
        end
        check("fill_full", full, 1);
        check("fill_count", count, FDEPTH);
        cyc(1'b1, 1'b1, 16'h0099, 1'b0);
        check("ovf_set", ovf, 1);
        check("ovf_count", count, FDEPTH);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", ovf, 0);

        // Push and pop together while full
        cyc(1'b1, 1'b1, 16'h0077, 1'b1);
        check("fullpp_count", count, FDEPTH);
        check("fullpp_ovf", ovf, 0);
        check("fullpp_full", full, 1);
        drain();
        check("fill_drained", exp_q.size(), 0);

        // Pointer wrap under continuous streaming
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b1);
            check("wrap_count_le1", count <= 1, 1);
        end
        drain();

        // Overflow set and clear in the same cycle: set wins
        for (int i = 0; i < FDEPTH; i++) cyc(1'b1, 1'b1, 16'h0300 + 16'(i), 1'b0);
        cyc(1'b1, 1'b1, 16'h0399, 1'b0, 1'b1);
        check("ovf_set_wins", ovf, 1);
        drain();

        // Reset with entries queued and a push in the reset cycle
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0);
        cyc(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
        check("midrst_count", count, 0);
        check("midrst_valid", m_if.m_valid, 0);
        check("midrst_ovf", ovf, 0);
        cyc(1'b1, 1'b1, 16'h0042, 1'b0);
        check("midrst_first", m_if.m_data, 16'h0042);
        drain();

        // Randomized traffic: a fill-biased phase, then a drain-biased phase
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 1)), 16'($urandom),
                (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end
        drain();
        check("final_empty", exp_q.size(), 0);
        check("final_valid", m_if.m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
